menu_arduino_tx: RTL and testbench



---
 rtl/menu_uart_pkg.sv | 47 ++++
 rtl/baud_counter.sv | 43 ++++
 rtl/menu_arduino_tx.sv | 152 +++++++++++++++
 tb/tb_menu_arduino_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/menu_uart_pkg.sv
// -----------------------------------------------------------------------------
// menu_uart_pkg
// Shared definitions for the menu -> Arduino UART link.
//   - tx_state_e : transmitter FSM states (IDLE, START, DATA, STOP)
//   - FRAME_W / SEL_W / VAL_W : frame and field widths
//   - *_LSB / RSV_BIT : bit positions of the fields inside the frame byte
//   - calc_div() / DEFAULT_DIV : clock cycles per UART bit (truncated)
//   - pack_frame() : builds the frame byte from the menu group and position
// -----------------------------------------------------------------------------
package menu_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int FRAME_W = 8;
   localparam int SEL_W   = 3;
   localparam int VAL_W   = 4;

   // Frame layout: [7] reserved (always 0), [6:4] menu group, [3:0] position
   localparam int VAL_LSB = 0;
   localparam int SEL_LSB = VAL_LSB + VAL_W;
   localparam int RSV_BIT = SEL_LSB + SEL_W;

   // Cycles per bit; integer division truncates, which is the intended rounding.
   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   localparam int DEFAULT_DIV = calc_div(50000000, 9600);

   function automatic logic [FRAME_W-1:0] pack_frame(
      input logic [SEL_W-1:0] sel,
      input logic [VAL_W-1:0] val
   );
      logic [FRAME_W-1:0] f;
      f = '0;
      f[SEL_LSB +: SEL_W] = sel;
      f[VAL_LSB +: VAL_W] = val;
      f[RSV_BIT]          = 1'b0;
      return f;
   endfunction

endpackage

// File: rtl/baud_counter.sv
// -----------------------------------------------------------------------------
// baud_counter
// Free-running modulo-DIV counter that paces one UART bit period.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low reset (count returns to 0)
//   clear : synchronous restart; next count is 0
//   tick  : high while the count equals DIV-1 (last cycle of a bit period)
// -----------------------------------------------------------------------------
module baud_counter #(
   parameter int DIV = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      // Explicit wrap: DIV need not be a power of two.
      if (clear || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/menu_arduino_tx.sv
// -----------------------------------------------------------------------------
// menu_arduino_tx
// Sends the current menu selection to the Arduino as one 8N1 UART byte
// {0, menu_sel, menu_value} whenever the pair differs from the last byte sent,
// after reset, or on a force_send pulse.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-low reset (aborts any frame, line high)
//   menu_sel   : menu group currently shown (3 bits)
//   menu_value : encoded position within the group (4 bits)
//   force_send : one-cycle resend request, honoured only while idle
//   tx         : UART line, idle high
//   busy       : high from first start-bit cycle to last stop-bit cycle
//   sent       : one-cycle pulse on the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module menu_arduino_tx
   import menu_uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 9600,
   parameter int STOP_BITS = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [SEL_W-1:0] menu_sel,
   input  logic [VAL_W-1:0] menu_value,
   input  logic             force_send,
   output logic             tx,
   output logic             busy,
   output logic             sent
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);

   // Stop-bit index is one bit wide; its terminal value depends on STOP_BITS.
   localparam logic STOP_LAST = (STOP_BITS >= 2) ? 1'b1 : 1'b0;
   localparam logic [2:0] LAST_BIT = 3'(FRAME_W - 1);

   tx_state_e          state_q,  state_d;
   logic [FRAME_W-1:0] shift_q,  shift_d;
   logic [FRAME_W-1:0] last_q,   last_d;
   logic               boot_q,   boot_d;
   logic [2:0]         idx_q,    idx_d;
   logic               stop_q,   stop_d;

   logic [FRAME_W-1:0] frame;
   logic               trigger;
   logic               tick;
   logic               cnt_clear;

   assign frame   = pack_frame(menu_sel, menu_value);
   assign trigger = (frame != last_q) || force_send || boot_q;

   // Counter sits at 0 while idle and restarts on every state change so each
   // state's first bit gets a full DIV cycles.
   assign cnt_clear = (state_q == ST_IDLE) || (state_d != state_q);

   baud_counter #(
      .DIV (DIV)
   ) u_baud (
      .clock (clock),
      .reset (reset),
      .clear (cnt_clear),
      .tick  (tick)
   );

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      last_d  = last_q;
      boot_d  = boot_q;
      idx_d   = idx_q;
      stop_d  = stop_q;

      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               shift_d = frame;
               last_d  = frame;
               boot_d  = 1'b0;
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (tick) begin
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (idx_q == LAST_BIT) begin
                  stop_d  = 1'b0;
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               if (stop_q == STOP_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decode registered state only, so reset drives them at once.
   always_comb begin
      tx   = 1'b1;
      busy = (state_q != ST_IDLE);
      sent = 1'b0;
      case (state_q)
         ST_START: tx = 1'b0;
         ST_DATA:  tx = shift_q[0];
         ST_STOP:  sent = tick && (stop_q == STOP_LAST);
         default:  tx = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         last_q  <= '0;
         boot_q  <= 1'b1;
         idx_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         boot_q  <= boot_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
      end
   end

endmodule

// File: tb/tb_menu_arduino_tx.sv
// -----------------------------------------------------------------------------
// tb_menu_arduino_tx
// Two transmitters (STOP_BITS=1 and STOP_BITS=2, DIV=8) share one stimulus.
// A frame-position model predicts tx/busy/sent every cycle; directed literal
// checks pin frame contents, timing and frame counts.
// -----------------------------------------------------------------------------
module tb_menu_arduino_tx;

   localparam int DIV_TB = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] menu_sel = 3'd0;
   logic [3:0] menu_value = 4'd0;
   logic       force_send = 1'b0;
   logic [1:0] tx_w;
   logic [1:0] busy_w;
   logic [1:0] sent_w;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   menu_arduino_tx #(.CLK_FREQ(80), .BAUD(10), .STOP_BITS(1)) dut0 (
      .clock(clock), .reset(reset), .menu_sel(menu_sel), .menu_value(menu_value),
      .force_send(force_send), .tx(tx_w[0]), .busy(busy_w[0]), .sent(sent_w[0]));

   menu_arduino_tx #(.CLK_FREQ(80), .BAUD(10), .STOP_BITS(2)) dut1 (
      .clock(clock), .reset(reset), .menu_sel(menu_sel), .menu_value(menu_value),
      .force_send(force_send), .tx(tx_w[1]), .busy(busy_w[1]), .sent(sent_w[1]));

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         if (failures < 40)
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // ---------------- model: frame position per instance ----------------
   // pos 0 = idle; pos 1..total = cycle number within the frame being sent.
   int         pos_m[2]   = '{0, 0};
   logic [7:0] last_m[2]  = '{8'h00, 8'h00};
   logic [7:0] frm_m[2]   = '{8'h00, 8'h00};
   bit         boot_m[2]  = '{1'b1, 1'b1};
   int         nframes[2] = '{0, 0};

   function automatic int total_of(input int m);
      // start + 8 data + stop bit(s), each DIV cycles
      return (9 + (m + 1)) * DIV_TB;
   endfunction

   function automatic logic [2:0] exp_out(input int pos, input logic [7:0] b, input int total);
      int bn;
      if (pos == 0) return 3'b100;           // {tx, busy, sent}
      bn = (pos - 1) / DIV_TB;
      if (bn == 0) return 3'b010;
      if (bn <= 8) return {b[bn-1], 1'b1, 1'b0};
      return {1'b1, 1'b1, (pos == total)};
   endfunction

   logic [7:0] cur_frame;
   assign cur_frame = {1'b0, menu_sel, menu_value};

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int m = 0; m < 2; m++) begin
            pos_m[m]  <= 0;
            last_m[m] <= 8'h00;
            boot_m[m] <= 1'b1;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            if (pos_m[m] == 0) begin
               if ((cur_frame != last_m[m]) || force_send || boot_m[m]) begin
                  last_m[m]  <= cur_frame;
                  frm_m[m]   <= cur_frame;
                  boot_m[m]  <= 1'b0;
                  pos_m[m]   <= 1;
                  nframes[m] <= nframes[m] + 1;
               end
            end else if (pos_m[m] == total_of(m)) begin
               pos_m[m] <= 0;
            end else begin
               pos_m[m] <= pos_m[m] + 1;
            end
         end
      end
   end

   // ---------------- compare + monitors (falling edge) ----------------
   int sent_cnt[2]  = '{0, 0};
   int busy_run[2]  = '{0, 0};
   int idle_run[2]  = '{0, 0};
   int busy_len[2]  = '{0, 0};
   int last_gap[2]  = '{0, 0};

   always @(negedge clock) begin
      for (int m = 0; m < 2; m++) begin
         logic [2:0] e;
         e = exp_out(pos_m[m], frm_m[m], total_of(m));
         chk($sformatf("cyc_tx%0d", m),   int'(tx_w[m]),   int'(e[2]));
         chk($sformatf("cyc_busy%0d", m), int'(busy_w[m]), int'(e[1]));
         chk($sformatf("cyc_sent%0d", m), int'(sent_w[m]), int'(e[0]));
         if (reset) begin
            if (busy_w[m]) begin
               if (busy_run[m] == 0) last_gap[m] = idle_run[m];
               busy_run[m]++;
               idle_run[m] = 0;
            end else begin
               idle_run[m]++;
               busy_run[m] = 0;
            end
            if (sent_w[m]) begin
               busy_len[m] = busy_run[m];
               sent_cnt[m]++;
            end
         end else begin
            busy_run[m] = 0;
            idle_run[m] = 0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_force();
      force_send = 1'b1;
      tick(1);
      force_send = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      logic [9:0] bits_35;
      int         seen;
      bits_35 = 10'b1001101010;   // stop, 0x35 MSB..LSB, start

      tick(3);
      chk("reset_tx", int'(tx_w), 3);
      chk("reset_busy", int'(busy_w), 0);
      reset = 1'b1;

      // 1. boot frame
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         tick(1);
         if (busy_w[0]) seen = 1;
      end
      chk("boot_start_seen", seen, 1);
      tick(100);
      chk("boot_nframes", nframes[0], 1);
      chk("boot_byte", int'(frm_m[0]), 8'h00);
      chk("boot_busy_len0", busy_len[0], 80);
      chk("boot_busy_len1", busy_len[1], 88);
      chk("boot_sent_cnt", sent_cnt[0], 1);

      // 2./3. 0x35 frame, updates to 6 then 7 while in flight
      menu_sel = 3'd3;
      menu_value = 4'd5;
      tick(1);
      chk("latency_busy", int'(busy_w[0]), 1);
      tick(3);
      for (int b = 0; b < 10; b++) begin
         chk($sformatf("bit35_%0d", b), int'(tx_w[0]), int'(bits_35[b]));
         if (b == 3) menu_value = 4'd6;
         if (b == 6) menu_value = 4'd7;
         tick(8);
      end
      tick(300);
      chk("mid_nframes0", nframes[0], 3);
      chk("mid_nframes1", nframes[1], 3);
      chk("mid_last_byte", int'(frm_m[0]), 8'h37);
      chk("mid_sent_cnt", sent_cnt[0], 3);
      chk("idle_gap", last_gap[0], 1);

      // 4. hold, then change-and-revert while busy
      tick(1000);
      chk("hold_nframes", nframes[0], 3);
      chk("hold_sent_cnt", sent_cnt[0], 3);
      menu_value = 4'd5;
      tick(10);
      menu_value = 4'd9;
      tick(10);
      menu_value = 4'd5;
      tick(300);
      chk("revert_nframes0", nframes[0], 4);
      chk("revert_nframes1", nframes[1], 4);
      chk("revert_sent_cnt", sent_cnt[0], 4);

      // 5. force in idle, then force while busy
      pulse_force();
      tick(300);
      chk("force_nframes", nframes[0], 5);
      chk("force_byte", int'(frm_m[0]), 8'h35);
      chk("force_sent_cnt", sent_cnt[0], 5);
      pulse_force();
      tick(20);
      pulse_force();
      tick(300);
      chk("force_busy_nframes", nframes[0], 6);
      chk("force_busy_sent_cnt", sent_cnt[0], 6);

      // 6. reset during data bit 3, then boot frame
      pulse_force();
      tick(35);
      chk("pre_reset_busy", int'(busy_w), 3);
      #2;
      reset = 1'b0;
      #1;
      chk("async_tx", int'(tx_w), 3);
      chk("async_busy", int'(busy_w), 0);
      tick(3);
      reset = 1'b1;
      tick(300);
      chk("reboot_nframes", nframes[0], 8);
      chk("reboot_sent_cnt", sent_cnt[0], 7);
      chk("reboot_byte", int'(frm_m[0]), 8'h35);
      chk("reboot_busy_len1", busy_len[1], 88);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
